// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit: mdOp encodings,
// default latencies and a helper sizing the busy counter.
package mdu_defs_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MADDU = 3'b111
  } mdOpE;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Counter width able to hold the longer of the two latencies.
  function automatic int cntWidth(input int multCycles, input int divCycles);
    int maxCycles;
    maxCycles = (multCycles > divCycles) ? multCycles : divCycles;
    return (maxCycles < 2) ? 1 : $clog2(maxCycles + 1);
  endfunction

endpackage

// File: rtl/mdu_counter.sv
// Loadable down-counter that paces a multi-cycle multiply/divide.
// busy is high while the count is non-zero; lastCycle flags the edge on
// which the result is committed and done pulses for the cycle after it.
module mdu_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] loadCount,
  output logic          busy,
  output logic          done,
  output logic          lastCycle
);

  logic [CW-1:0] count;
  logic          doneReg;

  // Load when idle, otherwise count down to zero; done follows the final count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (count == CW'(1));
      if (load && (count == '0)) begin
        count <= loadCount;
      end else if (count != '0) begin
        count <= count - CW'(1);
      end
    end
  end

  assign busy      = (count != '0);
  assign lastCycle = (count == CW'(1));
  assign done      = doneReg;

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning the HI/LO registers.
// mult/multu/div/divu compute their result at the accept edge, hold it in
// pending registers and commit it when the busy counter expires.
// Optional build macro MDU_MADD_EN enables madd/maddu (accumulate into HI/LO).
module mdu_unit
  import mdu_defs_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cntWidth(MULT_CYCLES, DIV_CYCLES);

  mdOpE op;
  logic accept, isMul, isDiv, load, lastCycle;
  logic [CW-1:0] loadCount;

  logic [2*WIDTH-1:0] prodS, prodU;
  logic divZero, signedOvf;
  logic [WIDTH-1:0] divisorS, divisorU, quotU, remU;
  logic signed [WIDTH-1:0] quotS, remS;

  logic [WIDTH-1:0] nextHi, nextLo, pendHi, pendLo;
  logic nextWrite, pendWrite;
`ifdef MDU_MADD_EN
  logic nextAcc, pendAcc;
`endif

  assign op = mdOpE'(mdOp);

  // Classify the request; only multiply/divide ops start the busy counter.
  always_comb begin
    isMul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    isMul = isMul || (op == OP_MADD) || (op == OP_MADDU);
`endif
    isDiv     = (op == OP_DIV) || (op == OP_DIVU);
    accept    = start && !busy;
    load      = accept && (isMul || isDiv);
    loadCount = isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  end

  // Products and quotients; the divisor is forced to 1 for divide-by-zero and
  // for the signed overflow case so the dividers never see an undefined input
  // (min / 1 already yields quotient = min, remainder = 0).
  always_comb begin
    prodS     = {{WIDTH{srcA[WIDTH-1]}}, srcA} * {{WIDTH{srcB[WIDTH-1]}}, srcB};
    prodU     = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};
    divZero   = (srcB == '0);
    signedOvf = (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (srcB == '1);
    divisorS  = (divZero || signedOvf) ? WIDTH'(1) : srcB;
    divisorU  = divZero ? WIDTH'(1) : srcB;
    quotS     = $signed(srcA) / $signed(divisorS);
    remS      = $signed(srcA) % $signed(divisorS);
    quotU     = srcA / divisorU;
    remU      = srcA % divisorU;
  end

  // Select the value to park in the pending registers for this op.
  always_comb begin
    nextHi    = '0;
    nextLo    = '0;
    nextWrite = 1'b0;
`ifdef MDU_MADD_EN
    nextAcc   = 1'b0;
`endif
    case (op)
      OP_MULT:  begin {nextHi, nextLo} = prodS; nextWrite = 1'b1; end
      OP_MULTU: begin {nextHi, nextLo} = prodU; nextWrite = 1'b1; end
      OP_DIV:   begin nextHi = remS; nextLo = quotS; nextWrite = !divZero; end
      OP_DIVU:  begin nextHi = remU; nextLo = quotU; nextWrite = !divZero; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin {nextHi, nextLo} = prodS; nextWrite = 1'b1; nextAcc = 1'b1; end
      OP_MADDU: begin {nextHi, nextLo} = prodU; nextWrite = 1'b1; nextAcc = 1'b1; end
`endif
      default: ;
    endcase
  end

  mdu_counter #(.CW(CW)) counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .loadCount(loadCount),
    .busy     (busy),
    .done     (done),
    .lastCycle(lastCycle)
  );

  // Latch pending results at accept, commit them on the counter's last cycle,
  // and service mthi/mtlo immediately when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendWrite <= 1'b0;
`ifdef MDU_MADD_EN
      pendAcc   <= 1'b0;
`endif
    end else begin
      if (load) begin
        pendHi    <= nextHi;
        pendLo    <= nextLo;
        pendWrite <= nextWrite;
`ifdef MDU_MADD_EN
        pendAcc   <= nextAcc;
`endif
      end
      if (lastCycle) begin
`ifdef MDU_MADD_EN
        if (pendAcc) begin
          {hi, lo} <= {hi, lo} + {pendHi, pendLo};
        end else if (pendWrite) begin
          hi <= pendHi;
          lo <= pendLo;
        end
`else
        if (pendWrite) begin
          hi <= pendHi;
          lo <= pendLo;
        end
`endif
      end else if (accept && (op == OP_MTHI)) begin
        hi <= srcA;
      end else if (accept && (op == OP_MTLO)) begin
        lo <= srcA;
      end
    end
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS datapath; the next generation of the combinational ALU.
- Sits beside the ALU in EX and owns the HI/LO registers.
- Multiply and divide take several cycles, signalled by a busy/done handshake; the hazard unit stalls on `busy`.
- Move ops (mthi/mtlo) complete in one cycle; HI and LO are exposed continuously so mfhi/mflo reduce to a mux outside this block.

Parameters:
- WIDTH, 32: operand width and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range ≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled on clk rising edge.
- mdOp  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 madd/maddu (feature only).
- srcA  in  WIDTH  rs operand / dividend / mthi-mtlo source.
- srcB  in  WIDTH  rt operand / divisor.
- busy  out  1  high while a mult/div is in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO take a mult/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: asynchronous, active-high. hi=0, lo=0, busy=0, done=0, counter=0, pending results=0. Reset mid-operation aborts the op; its result is never committed.
- Accept rule: an op is accepted only when start=1 and busy=0. Start while busy is ignored; no queueing, no error.
- mthi/mtlo when accepted: hi (or lo) <= srcA at that edge; busy stays 0; done stays 0.
- mult/div when accepted at edge t:
  - Compute the result combinationally from srcA/srcB and latch it into pending regs at edge t.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; busy=1 from edge t.
  - The counter decrements each edge. On the edge where counter==1: commit pending to hi/lo, busy<=0, done<=1 for one cycle.
  - Net timing: busy high for exactly N cycles; the new hi/lo value is visible in the first cycle busy is low.
- Operands are sampled only at the accept edge; srcA/srcB changes during busy have no effect.
- mult: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits.
- multu: as mult, unsigned.
- div: lo=quotient truncated toward zero; hi=remainder, which takes the dividend's sign.
- divu: unsigned quotient and remainder.
- Divide by zero (srcB=0): full busy/done timing runs; hi/lo are left unchanged at commit.
- Signed overflow (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0 (WIDTH=32).
- mdOp 110/111 with the feature disabled: treated as no-op; busy=0, no register change.
- Back-to-back: a new start in the cycle done=1 is accepted, since busy is already 0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - mdOp 110 = madd, 111 = maddu.
  - {hi,lo} <= {hi,lo} + product (signed or unsigned respectively), modulo 2^(2*WIDTH).
  - MULT_CYCLES latency.
  - The accumulate uses the hi/lo value present at commit, so an mthi/mtlo cannot intervene because busy blocks it.
- Undefined: 110/111 decode as no-op as above; no accumulate adder is synthesised.

Decomposition:
- Shared package / include file mdu_defs: 3-bit mdOp encodings as named constants, and the default cycle counts.
- One natural sub-module: mdu_counter, a loadable down-counter that produces busy and the done pulse and takes the cycle count as an input. The arithmetic and HI/LO registers stay in mdu_unit.

Test Plan:
- mult: srcA=0xFFFFFFFE (-2), srcB=3, start 1 cycle -> busy=1 for 5 cycles, done pulses once; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu: same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- div: srcA=-7, srcB=2 -> busy for 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu: srcA=7, srcB=0 with prior hi=0x11, lo=0x22 -> 10 busy cycles with done; hi/lo remain 0x11/0x22.
- Busy and reset:
  - A second start (mtlo, srcA=0x55) during busy is ignored; lo is unchanged apart from the mult result.
  - Assert reset at busy cycle 3 -> busy, done, hi, lo = 0 immediately, with no later commit.
- mthi 0xABCD then mtlo 0x1234 on consecutive cycles -> hi=0xABCD, lo=0x1234; busy never asserted.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu srcA=1, srcB=1 -> hi=1, lo=0 after 5 cycles.
